adder_seq_n: RTL and testbench
==============================

Name: adder_seq_N

Overview:
- Multi-cycle, parametrised successor to the team's combinational N-bit adder.
- Adds or subtracts two N-bit operands W bits per clock, carrying through a registered carry.
- Uses valid/ready handshakes on input and output.
- Sits between operand registers and the result bus where a full-width carry chain is too slow or too large.

Parameters:
- N, 8, total operand/result width; must be an integer multiple of W.
- W, 2, chunk width processed per clock; 1 <= W <= N.
- K (localparam), N/W, number of chunk cycles per operation.

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- A  input  N  operand A.
- B  input  N  operand B.
- Cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- Sum  output  N  result.
- Cout  output  1  carry-out; for subtract, 1 = no borrow.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (n_reset).
- Reset (asserted at any time, including mid-operation): operation aborted, state = IDLE, in_ready = 1, out_valid = 0, Sum = 0, Cout = 0, internal carry and chunk counter = 0.
- Arithmetic:
  - Beff = sub ? ~B : B; cin_eff = sub ? ~Cin : Cin.
  - {Cout, Sum} = A + Beff + cin_eff, computed modulo 2^(N+1).
  - sub=1, Cin=0 gives A-B; sub=1, Cin=1 gives A-B-1.
- Capture: A, Beff and cin_eff are registered on the accepting edge. Later input changes have no effect.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - in_valid=1 at a rising edge: capture operands, chunk index i=0, carry=cin_eff, go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge: {carry, Sum[i*W +: W]} = A[i*W +: W] + Beff[i*W +: W] + carry; i increments.
  - After chunk K-1: Cout = final carry, go to DONE.
  - Exactly K clocks in RUN.
- DONE:
  - out_valid = 1, in_ready = 0.
  - Sum and Cout held stable.
  - out_ready=1 at an edge: go to IDLE, out_valid drops next cycle.
  - out_ready=0: wait indefinitely (backpressure).
- Latency: accept at edge t; out_valid high from edge t+K; earliest next accept at edge t+K+2 (DONE handshake, then IDLE).
- Sum during RUN: chunks not yet processed read 0; Sum is cleared on accept.
- No back-to-back overlap: in_valid is ignored outside IDLE, and in_ready never rises in the same cycle as the output handshake.
- Wrap-around: all-ones + 1 gives Sum=0, Cout=1. Carry propagates across every chunk boundary.
- W=N: K=1, single RUN cycle, same handshake.

Optional Feature:
- Macro: ADDER_SEQ_OVF_EN.
- Defined:
  - Extra output port Ovf (output, 1 bit), signed two's-complement overflow.
  - Ovf = (A[N-1] == Beff[N-1]) && (Sum[N-1] != A[N-1]), evaluated on the last chunk.
  - Ovf is registered with Cout, valid in DONE, held with Sum, and reset to 0.
- Undefined: no Ovf port and no associated logic; all other behaviour identical.

Test Plan:
- Reset mid-operation: accept A=8'h12, B=8'h34, assert n_reset=0 in RUN -> immediately in_ready=1, out_valid=0, Sum=0, Cout=0; next accept works normally.
- Basic add (N=8, W=2): A=8'h3C, B=8'h47, Cin=0, sub=0 -> out_valid exactly 4 cycles after accept, Sum=8'h83, Cout=0; with ADDER_SEQ_OVF_EN, Ovf=1.
- Full ripple: A=8'hFF, B=8'h00, Cin=1 -> Sum=8'h00, Cout=1; carry crosses all 4 chunk boundaries.
- Subtract and borrow:
  - A=8'h05, B=8'h07, sub=1, Cin=0 -> Sum=8'hFE, Cout=0.
  - A=8'h07, B=8'h05, sub=1, Cin=1 -> Sum=8'h01, Cout=1.
- Backpressure and capture: hold out_ready=0 for 10 cycles in DONE while changing A/B/in_valid -> Sum/Cout stable, in_ready=0, no new accept; release out_ready -> IDLE next cycle.
- Signed overflow (macro defined): A=8'h80, B=8'h01, sub=1, Cin=0 -> Sum=8'h7F, Cout=1, Ovf=1. Repeat with macro undefined -> same Sum/Cout, no Ovf port, compiles clean.

Source files
------------

// File: rtl/adder_seq_n.sv
// adder_seq_n: multi-cycle N-bit adder/subtractor that processes W bits per
// clock through a registered carry, with valid/ready handshakes on both sides.
// Optional signed-overflow output Ovf is enabled by defining ADDER_SEQ_OVF_EN.
// N must be an integer multiple of W, and 1 <= W <= N.
module adder_seq_n #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         Cout
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic         Ovf
`endif
);

    localparam int K     = N / W;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;       // B already inverted for subtract
    logic           carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
`ifdef ADDER_SEQ_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    // Operand registers viewed as arrays of W-bit chunks, selected by idx_q
    logic [W-1:0] a_chunk [K];
    logic [W-1:0] b_chunk [K];

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_chunk
            assign a_chunk[gi] = a_q[gi*W +: W];
            assign b_chunk[gi] = b_q[gi*W +: W];
        end
    endgenerate

    // One W-bit slice of the ripple, carry-out in the top bit
    logic [W:0] chunk_res;
    assign chunk_res = {1'b0, a_chunk[idx_q]} + {1'b0, b_chunk[idx_q]}
                     + {{W{1'b0}}, carry_q};

    // Next-state and datapath: capture in IDLE, one chunk per clock in RUN,
    // hold the result in DONE until the consumer takes it
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = A;
                    b_d        = sub ? ~B : B;
                    carry_d    = sub ? ~Cin : Cin;
                    idx_d      = '0;
                    sum_d      = '0;
                    cout_d     = 1'b0;
`ifdef ADDER_SEQ_OVF_EN
                    ovf_d      = 1'b0;
`endif
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*W +: W] = chunk_res[W-1:0];
                carry_d             = chunk_res[W];
                if (idx_q == LAST_IDX) begin
                    cout_d      = chunk_res[W];
`ifdef ADDER_SEQ_OVF_EN
                    // chunk_res[W-1] is result bit N-1 on the last chunk
                    ovf_d       = (a_q[N-1] == b_q[N-1]) && (chunk_res[W-1] != a_q[N-1]);
`endif
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    carry_d     = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq_n.sv
// tb_adder_seq_n: directed scoreboard bench for adder_seq_n (N=8, W=2).
// Defining ADDER_SEQ_OVF_EN also checks the Ovf output.
module tb_adder_seq_n;

    localparam int N = 8;
    localparam int W = 2;
    localparam int K = N / W;

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] Sum;
    logic         Cout;
`ifdef ADDER_SEQ_OVF_EN
    logic         Ovf;
`endif

    adder_seq_n #(.N(N), .W(W)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation; the reference result goes to the scoreboard
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic s);
        logic [N-1:0] beff;
        logic         ceff;
        logic [N:0]   full;
        exp_t         e;
        int           cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check("in_ready_wait", {8'h0, in_ready}, 9'h1);
        beff = s ? ~b : b;
        ceff = s ? ~cin : cin;
        full = {1'b0, a} + {1'b0, beff} + {{N{1'b0}}, ceff};
        e.sum  = full[N-1:0];
        e.cout = full[N];
        e.ovf  = (a[N-1] == beff[N-1]) && (full[N-1] != a[N-1]);
        sb.push_back(e);
        A = a; B = b; Cin = cin; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = ~a; B = ~b; Cin = ~cin; sub = ~s;   // later changes must not matter
        check("accept_in_ready", {8'h0, in_ready}, 9'h0);
        check("sum_clear", {1'b0, Sum}, {1'b0, 8'h00});
    endtask

    // Wait for the result, check latency and value, then hand it off
    task automatic receive(input int hold);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("latency", 9'(cyc), 9'(K));
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            check("sum", {1'b0, Sum}, {1'b0, e.sum});
            check("cout", {8'h0, Cout}, {8'h0, e.cout});
`ifdef ADDER_SEQ_OVF_EN
            check("ovf", {8'h0, Ovf}, {8'h0, e.ovf});
`endif
            check("done_in_ready", {8'h0, in_ready}, 9'h0);
            check("done_valid", {8'h0, out_valid}, 9'h1);
            if (h < hold) begin
                A = N'($urandom); B = N'($urandom); in_valid = 1'($urandom);
                tick();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", {8'h0, out_valid}, 9'h0);
        check("release_ready", {8'h0, in_ready}, 9'h1);
        $display("txn: sum=%h cout=%0d ovf=%0d latency=%0d", e.sum, e.cout, e.ovf, cyc);
    endtask

    initial begin
        // Reset state
        n_reset = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {8'h0, in_ready}, 9'h1);
        check("rst_out_valid", {8'h0, out_valid}, 9'h0);
        check("rst_sum", {1'b0, Sum}, 9'h0);
        n_reset = 1'b1;
        tick();

        // Reset mid-operation
        send(8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        n_reset = 1'b0;
        #1;
        check("mid_rst_in_ready", {8'h0, in_ready}, 9'h1);
        check("mid_rst_out_valid", {8'h0, out_valid}, 9'h0);
        check("mid_rst_sum", {1'b0, Sum}, 9'h0);
        check("mid_rst_cout", {8'h0, Cout}, 9'h0);
        sb.delete();
        $display("txn: reset mid-operation");
        tick();
        n_reset = 1'b1;
        tick();

        // Directed vectors
        send(8'h3C, 8'h47, 1'b0, 1'b0); receive(0);   // 83, Cout 0, Ovf 1
        send(8'hFF, 8'h00, 1'b1, 1'b0); receive(0);   // full ripple: 00, Cout 1
        send(8'h05, 8'h07, 1'b0, 1'b1); receive(0);   // FE, borrow
        send(8'h07, 8'h05, 1'b1, 1'b1); receive(0);   // 01, no borrow
        send(8'h80, 8'h01, 1'b0, 1'b1); receive(0);   // 7F, Cout 1, Ovf 1
        send(8'hAA, 8'h55, 1'b1, 1'b0); receive(0);

        // Backpressure with input churn in DONE
        send(8'h9D, 8'h6B, 1'b1, 1'b0); receive(10);

        // A few random operations
        for (int r = 0; r < 6; r++) begin
            send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
            receive(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
